// File: rtl/fetch_unit.sv
// fetch_unit: program counter, imem request, 2-entry skid FIFO
// and redirect / HALT control for the 16-bit pipelined CPU.
module fetch_unit #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OP  = 4'b1111
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [15:0]     instruction_out,
  output logic [PC_W-1:0] pc_out,
  output logic            halted
);

  typedef enum logic {
    S_RUN,
    S_HALTED
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t          r_state;
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_req_pc;
  logic            r_inflight;
  logic            r_live;
  logic [15:0]     r_instr [2];
  logic [PC_W-1:0] r_pc    [2];
  logic            r_head;
  logic [1:0]      r_count;

  logic            w_pop;
  logic            w_push;
  logic            w_is_halt;
  logic            w_halt_push;
  logic [2:0]      w_credit;
  logic            w_tail;

  assign out_valid   = (r_count != 2'd0);
  assign w_pop       = out_valid & out_ready;
  assign w_push      = r_inflight & r_live & ~redirect;
  assign w_is_halt   = (imem_rdata[15:12] == HALT_OP);
  assign w_halt_push = w_push & w_is_halt;
  // Slots committed next cycle: held entries after pop plus the
  // response already on its way back.
  assign w_credit    = {1'b0, r_count} - {2'b0, w_pop}
                     + {2'b0, r_inflight};
  assign imem_req    = rst & (r_state == S_RUN) & ~redirect
                     & (w_credit < 3'd2);
  assign imem_addr   = r_fetch_pc;
  assign w_tail      = r_head ^ r_count[0];

  assign instruction_out = out_valid ? r_instr[r_head] : 16'h0000;
  assign pc_out          = out_valid ? r_pc[r_head] : '0;
  assign halted          = (r_state == S_HALTED) & ~out_valid
                         & ~r_inflight;

  // Run/halt state, PC and in-flight epoch tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_RUN;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_live     <= 1'b0;
    end else if (redirect) begin
      r_state    <= S_RUN;
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
      r_live     <= 1'b0;
    end else begin
      r_inflight <= imem_req;
      // A request issued alongside a HALT push is stale on arrival.
      r_live     <= imem_req & ~w_halt_push;
      if (imem_req) begin
        r_fetch_pc <= r_fetch_pc + PC_ONE;
        r_req_pc   <= r_fetch_pc;
      end
      if (w_halt_push) begin
        r_state <= S_HALTED;
      end
    end
  end

  // Skid FIFO: flush on redirect, write at tail, advance head on pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head     <= 1'b0;
      r_count    <= 2'd0;
      r_instr[0] <= 16'h0000;
      r_instr[1] <= 16'h0000;
      r_pc[0]    <= '0;
      r_pc[1]    <= '0;
    end else if (redirect) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_instr[w_tail] <= imem_rdata;
        r_pc[w_tail]    <= r_req_pc;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random redirect/backpressure/HALT
// traffic checked against a stream-level model of fetch order.
module tb_fetch_unit;

  localparam logic [15:0] RST_PC = 16'hFFFE;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] instruction_out;
  logic [15:0] pc_out;
  logic        halted;

  fetch_unit #(
    .PC_W    (16),
    .RESET_PC(RST_PC),
    .HALT_OP (4'b1111)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .instruction_out(instruction_out),
    .pc_out         (pc_out),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        halt_en = 1'b0;
  logic [15:0] halt_addr = 16'h0000;
  logic        nxt_halt_en = 1'b0;
  logic [15:0] nxt_halt_addr = 16'h0000;

  // ROM contents: a+0x100 with top bit cleared, one optional HALT word
  function automatic logic [15:0] rom(input logic [15:0] a);
    if (halt_en && a == halt_addr) return {4'hF, a[11:0]};
    return (a + 16'h0100) & 16'h7FFF;
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= rom(imem_addr);
  end

  // stream model
  logic [15:0] exp_pc;
  logic [15:0] next_req;
  logic [15:0] rd_pc;
  bit          after_halt;
  bit          hold;
  bit          post_rd;
  int          lat = -1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic rd, input logic [15:0] rpc,
                     input logic rdy);
    logic [15:0] diff;
    logic [15:0] w;
    @(negedge clk);
    rst = 1'b1;
    redirect = rd;
    redirect_pc = rpc;
    out_ready = rdy;
    #1;
    if (lat > 0) lat--;
    chk("halted", halted, after_halt);
    if (after_halt) begin
      chk("req_after_halt", imem_req, 0);
      chk("valid_after_halt", out_valid, 0);
    end
    if (hold) chk("hold_valid", out_valid, 1);
    if (post_rd) begin
      chk("restart_bubble", out_valid, 0);
      if (!rd) chk("restart_req", {imem_req, imem_addr}, {1'b1, rd_pc});
    end
    if (lat == 0) begin
      chk("restart_lat_valid", out_valid, 1);
      chk("restart_lat_pc", pc_out, rd_pc);
      lat = -1;
    end
    if (out_valid) begin
      chk("pc_out", pc_out, exp_pc);
      chk("instr", instruction_out, rom(exp_pc));
    end else begin
      chk("idle_zero", {instruction_out, pc_out}, 0);
    end
    if (rd) chk("redirect_no_req", imem_req, 0);
    if (imem_req) begin
      chk("req_addr", imem_addr, next_req);
      next_req++;
    end
    diff = next_req - exp_pc;
    chk("credit", diff <= 16'd3, 1);
    hold = out_valid & ~rdy & ~rd;
    post_rd = 1'b0;
    if (rd) begin
      exp_pc = rpc;
      next_req = rpc;
      rd_pc = rpc;
      after_halt = 1'b0;
      post_rd = 1'b1;
      lat = 3;
      halt_en = nxt_halt_en;
      halt_addr = nxt_halt_addr;
    end else if (out_valid && rdy) begin
      w = rom(exp_pc);
      if (w[15:12] == 4'hF) after_halt = 1'b1;
      exp_pc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    redirect = 1'b0;
    out_ready = 1'($urandom);
    #1;
    chk("rst_req_low", imem_req, 0);
    @(negedge clk);
    out_ready = ~out_ready;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", instruction_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_halted", halted, 0);
    chk("rst_req", imem_req, 0);
    halt_en = nxt_halt_en;
    halt_addr = nxt_halt_addr;
    exp_pc = RST_PC;
    next_req = RST_PC;
    rd_pc = RST_PC;
    after_halt = 1'b0;
    hold = 1'b0;
    post_rd = 1'b1;
    lat = 3;
  endtask

  initial begin
    logic        rd;
    logic [15:0] rpc;
    do_reset();
    // free run through the FFFF->0000 wrap up to pc 4
    for (int i = 0; i < 8; i++) cyc(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 16'h0, 1'b0);
      if (i == 0) chk("bp_pc4", pc_out, 16'h0004);
    end
    chk("bp_req_drop", imem_req, 0);
    chk("bp_full_valid", out_valid, 1);
    // redirect while FIFO full
    cyc(1'b1, 16'h0040, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b1);
    // HALT at address 3
    nxt_halt_en = 1'b1;
    nxt_halt_addr = 16'h0003;
    cyc(1'b1, 16'h0000, 1'b1);
    for (int i = 0; i < 20 && !halted; i++) cyc(1'b0, 16'h0, 1'b1);
    chk("halt_reached", halted, 1);
    chk("halt_no_req", imem_req, 0);
    nxt_halt_en = 1'b0;
    cyc(1'b1, 16'h0010, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    chk("unhalt", halted, 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1);
    // redirect lands on the cycle the HALT response arrives
    nxt_halt_en = 1'b1;
    nxt_halt_addr = 16'h0050;
    cyc(1'b1, 16'h0050, 1'b1);
    nxt_halt_en = 1'b0;
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b1, 16'h0020, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b1);
    // mid-stream reset with toggling ready
    for (int i = 0; i < 6; i++) cyc(1'b0, 16'h0, 1'(i));
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b0, 16'h0, 1'b1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        nxt_halt_en = 1'b0;
        do_reset();
      end else begin
        rd = ($urandom_range(0, 15) == 0);
        rpc = 16'($urandom);
        if (rd) begin
          nxt_halt_en = 1'($urandom);
          nxt_halt_addr = rpc + 16'($urandom_range(0, 5));
        end
        cyc(rd, rpc, $urandom_range(0, 3) != 0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
